// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment hex driver with blanking between
// digits, tear-free frame-boundary updates and optional leading-zero blanking.
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  lzs,
   output logic [6:0]            seg7,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an_n,
   output logic                  frame_done
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]         cnt_reg;
   logic [IW-1:0]         idx_reg;
   logic [4*DIGITS-1:0]   active_val_reg;
   logic [DIGITS-1:0]     active_dp_reg;
   logic [4*DIGITS-1:0]   pend_val_reg;
   logic [DIGITS-1:0]     pend_dp_reg;
   logic                  pend_v_reg;
   logic [6:0]            seg7_reg;
   logic                  dp_n_reg;
   logic [DIGITS-1:0]     an_n_reg;
   logic                  frame_done_reg;

   logic                  slot_end;
   logic                  boundary;
   logic                  blank;
   logic [DIGITS-1:0]     zero_up;
   logic [6:0]            seg_dig [DIGITS];
   logic [DIGITS-1:0]     onehot;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0001100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   assign slot_end = (cnt_reg == CNT_LAST);
   assign boundary = enable && slot_end && (idx_reg == IDX_LAST);
   assign onehot   = DIGITS'(1) << idx_reg;

   generate
      if (BLANK_CYCLES == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt_reg < CW'(BLANK_CYCLES));
      end
   endgenerate

   // zero_up[i]: nibble i and every nibble above it are zero.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
         logic [3:0] nib;
         assign nib = active_val_reg[4*gi +: 4];
         if (gi == DIGITS - 1) begin : g_top
            assign zero_up[gi] = (nib == 4'h0);
         end else begin : g_low
            assign zero_up[gi] = (nib == 4'h0) && zero_up[gi+1];
         end
         if (gi == 0) begin : g_d0
            assign seg_dig[gi] = hex7(nib);
         end else begin : g_dn
            assign seg_dig[gi] = (lzs && zero_up[gi]) ? 7'h7F : hex7(nib);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         idx_reg        <= '0;
         active_val_reg <= '0;
         active_dp_reg  <= '0;
         pend_val_reg   <= '0;
         pend_dp_reg    <= '0;
         pend_v_reg     <= 1'b0;
         seg7_reg       <= 7'h7F;
         dp_n_reg       <= 1'b1;
         an_n_reg       <= '1;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= boundary;

         if (!enable) begin
            cnt_reg <= '0;
            idx_reg <= '0;
         end else if (slot_end) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end

         // A load landing on the boundary bypasses the pending buffer.
         if (boundary && load) begin
            active_val_reg <= value;
            active_dp_reg  <= dp;
            pend_v_reg     <= 1'b0;
         end else if (boundary && pend_v_reg) begin
            active_val_reg <= pend_val_reg;
            active_dp_reg  <= pend_dp_reg;
            pend_v_reg     <= 1'b0;
         end else if (load) begin
            pend_val_reg   <= value;
            pend_dp_reg    <= dp;
            pend_v_reg     <= 1'b1;
         end

         if (!enable || blank) begin
            seg7_reg <= 7'h7F;
            dp_n_reg <= 1'b1;
            an_n_reg <= '1;
         end else begin
            seg7_reg <= seg_dig[idx_reg];
            dp_n_reg <= ~active_dp_reg[idx_reg];
            an_n_reg <= ~onehot;
         end
      end
   end

   assign seg7       = seg7_reg;
   assign dp_n       = dp_n_reg;
   assign an_n       = an_n_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scans whole frames cycle by cycle and
// compares {seg7,dp_n,an_n,frame_done} against hand-computed digit patterns.
module tb_seg7_scan_driver;

   localparam logic [6:0] OFF = 7'h7F;
   localparam logic [6:0] H0  = 7'b0000001;
   localparam logic [6:0] H1  = 7'b1001111;
   localparam logic [6:0] H2  = 7'b0010010;
   localparam logic [6:0] H3  = 7'b0000110;
   localparam logic [6:0] H4  = 7'b1001100;
   localparam logic [6:0] H5  = 7'b0100100;
   localparam logic [6:0] H8  = 7'b0000000;
   localparam logic [6:0] HA  = 7'b0001000;
   localparam logic [6:0] HB  = 7'b1100000;
   localparam logic [6:0] HE  = 7'b0110000;
   localparam logic [6:0] HF  = 7'b0111000;
   localparam logic [12:0] ALL_OFF = {OFF, 1'b1, 4'hF, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic        lzs = 1'b0;
   logic [6:0]  seg7;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp         (dp),
      .lzs        (lzs),
      .seg7       (seg7),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [12:0] obs();
      return {seg7, dp_n, an_n, frame_done};
   endfunction

   // Runs ncyc cycles from the cycle that samples cnt=0/idx=0. Slot 0 of each
   // digit is blank; frame_done is seen after the edge that samples cnt=3/idx=3.
   // l1/l2 are cycle numbers at which a load strobe is presented.
   task automatic run_frame(input string name,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] edp, input int ncyc,
                            input int l1, input logic [15:0] v1, input logic [3:0] d1,
                            input int l2, input logic [15:0] v2);
      logic [6:0]  s [4];
      logic [12:0] want;
      int c, d;
      s = '{s0, s1, s2, s3};
      for (int j = 0; j < ncyc; j++) begin
         if (j == l1) begin
            load = 1'b1; value = v1; dp = d1;
         end else if (j == l2) begin
            load = 1'b1; value = v2; dp = d1;
         end
         @(posedge clk);
         #1;
         load = 1'b0;
         c = j % 4;
         d = j / 4;
         if (c == 0)
            want = ALL_OFF;
         else
            want = {s[d], ~edp[d], ~(4'b0001 << d), (j == 15)};
         chk($sformatf("%s_c%0d", name, j), 32'(obs()), 32'(want));
         $display("%s cycle %0d: seg7=%b dp_n=%b an_n=%b fd=%b", name, j, seg7, dp_n, an_n, frame_done);
      end
   endtask

   initial begin
      enable = 1'b1;
      #12;
      chk("reset_outputs", 32'(obs()), 32'(ALL_OFF));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_frame("A_zero",   H0, H0, H0, H0, 4'b0000, 16,  6, 16'h1A2F, 4'b0100, -1, 16'h0);
      run_frame("B_1A2F",   HF, H2, HA, H1, 4'b0100, 16,  3, 16'h1111, 4'b0000,  9, 16'h2222);
      run_frame("C_2222",   H2, H2, H2, H2, 4'b0000, 16, 15, 16'h8E3B, 4'b1001, -1, 16'h0);
      run_frame("D_8E3B",   HB, H3, HE, H8, 4'b1001, 16,  2, 16'h0050, 4'b1000, -1, 16'h0);
      lzs = 1'b1;
      run_frame("E_lzs50",  H0, H5, OFF, OFF, 4'b1000, 16, 4, 16'h0000, 4'b0000, -1, 16'h0);
      run_frame("F_lzs00",  H0, OFF, OFF, OFF, 4'b0000, 16, -1, 16'h0, 4'b0000, -1, 16'h0);
      lzs = 1'b0;
      run_frame("G_part",   H0, H0, H0, H0, 4'b0000, 6, -1, 16'h0, 4'b0000, -1, 16'h0);

      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("enable_drop", 32'(obs()), 32'(ALL_OFF));
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            load = 1'b1; value = 16'h4321; dp = 4'b0010;
         end
         @(posedge clk);
         #1;
         load = 1'b0;
         chk($sformatf("disabled_%0d", k), 32'(obs()), 32'(ALL_OFF));
      end
      enable = 1'b1;
      run_frame("H_reen",   H0, H0, H0, H0, 4'b0000, 16, -1, 16'h0, 4'b0000, -1, 16'h0);
      run_frame("I_4321",   H1, H2, H3, H4, 4'b0010, 16, -1, 16'h0, 4'b0000, -1, 16'h0);
      run_frame("J_part",   H1, H2, H3, H4, 4'b0010, 6, 3, 16'h9999, 4'b1111, -1, 16'h0);

      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 32'(obs()), 32'(ALL_OFF));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame("K_rst",    H0, H0, H0, H0, 4'b0000, 16, -1, 16'h0, 4'b0000, -1, 16'h0);
      run_frame("L_nopend", H0, H0, H0, H0, 4'b0000, 16, -1, 16'h0, 4'b0000, -1, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment hex display.
- Accepts a packed hex value, per-digit decimal points and a load strobe, then scans one digit per slot.
- Includes an inter-digit blanking window, tear-free frame-boundary updates and optional leading-zero suppression.
- Sits between the core datapath and the board display pins, replacing direct per-digit combinational decoding.

Parameters:
- DIGITS, 4, number of digits scanned (1..16).
- PRESCALE, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all outputs off (0 <= BLANK_CYCLES < PRESCALE).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan; 0 = display off.
- load  in  1  single-cycle strobe that captures value/dp.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) maps to digit i; digit 0 is least significant.
- dp  in  DIGITS  decimal point per digit, active high.
- lzs  in  1  1 = suppress leading zeros (sampled live).
- seg7  out  7  segments {a,b,c,d,e,f,g}, active low.
- dp_n  out  1  decimal point, active low.
- an_n  out  DIGITS  digit anode select, active low, one-hot-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0.
  - active, pending and pend_v cleared.
  - seg7=7'h7F, dp_n=1, an_n=all 1, frame_done=0.
- Slot counter:
  - cnt counts 0..PRESCALE-1.
  - At cnt==PRESCALE-1, cnt wraps to 0 and idx advances (DIGITS-1 -> 0).
  - frame_done=1 in the cycle after cnt==PRESCALE-1 with idx==DIGITS-1.
- Load path:
  - load=1 writes value/dp into pending and sets pend_v.
  - A second load before the frame boundary overwrites pending; last value wins.
- Frame boundary (cnt==PRESCALE-1 and idx==DIGITS-1):
  - If pend_v, pending is copied to active and pend_v clears.
  - If load coincides with the boundary, active takes the input value/dp directly and pend_v stays 0.
  - The display therefore never shows a mix of old and new digits within one frame.
- Outputs are registered and reflect the cnt/idx of the previous cycle (latency 1):
  - Blank window (cnt < BLANK_CYCLES) or enable=0: seg7=7'h7F, dp_n=1, an_n=all 1.
  - Otherwise:
    - an_n = ~(1<<idx).
    - seg7 = hex decode of active nibble idx.
    - dp_n = ~active_dp[idx].
- Hex decode (active low, {a..g}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression:
  - With lzs=1, digit i>0 is suppressed when it and every nibble above it are 0; its seg7 is 7'h7F.
  - an_n and dp_n for a suppressed digit behave normally.
  - Digit 0 is never suppressed.
- Enable:
  - enable=0 holds cnt=0, idx=0 and frame_done=0.
  - Loads are still accepted; a pending load is applied at the first frame boundary after re-enable.
- Reset mid-frame: everything returns to reset values immediately and any pending load is discarded.

Test Plan (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1):
- Reset release, enable=1, no load:
  - Each slot has 1 blank cycle, then 3 cycles of "0".
  - an_n steps 1110, 1101, 1011, 0111.
  - frame_done pulses every 16 cycles.
- load value=16'h1A2F, dp=4'b0100 mid-frame:
  - The current frame still shows 0000.
  - The next frame shows digit0=0111000, digit1=0010010, digit2=0001000 with dp_n=0, digit3=1001111.
- Two loads in one frame (16'h1111 then 16'h2222): the next frame shows 2222 only.
- load coinciding with the boundary cycle: the new value appears in the immediately following frame.
- lzs=1, value=16'h0050:
  - Digits 3 and 2 have seg7=7'h7F.
  - Digit 1 shows "5"; digit 0 shows "0".
  - With value=0, digit 0 still shows "0".
- Mid-frame checks:
  - enable dropped mid-frame: the next cycle is all outputs off, cnt/idx=0.
  - rst_n asserted mid-frame: outputs go off asynchronously and the pending load is lost.
